// File: rtl/obstacle_collision_detector_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_collision_detector_pkg
// Shared game constants for the collision detector slice.
//   - gameState encodings driven by the game-state controller
//   - active screen geometry of the VGA timing
//   - detector FSM state type and its state constants
// ---------------------------------------------------------------------------
package obstacle_collision_detector_pkg;

    // gameState encodings; 2'b11 is treated as paused by the detector
    localparam logic [1:0] GS_IDLE  = 2'b00;
    localparam logic [1:0] GS_RUN   = 2'b10;
    localparam logic [1:0] GS_PAUSE = 2'b01;

    // Active display area
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Detector FSM states
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_GRACE = 2'd1;
    localparam fsm_state_t ST_ARMED = 2'd2;
    localparam fsm_state_t ST_HIT   = 2'd3;

endpackage

// File: rtl/obstacle_collision_detector_overlap_frame_counter.sv
// ---------------------------------------------------------------------------
// overlap_frame_counter
// Per-frame count of overlapping solid pixels, first-overlap capture and
// end-of-frame snapshot.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   pixelEn         one-cycle-per-pixel enable
//   vgaX, vgaY      current pixel position
//   overlapPix      current pixel is a qualified overlap (already pixelEn-gated)
//   frameEnd        current pixel is the last active pixel of the frame
//   freeze          hold all state (pause)
//   clear           synchronous clear of everything, applies every clk
//   overlapCount    count of the last completed frame
//   frameTotal      count including the current pixel (saturating)
//   firstX, firstY  first overlap position of the frame, including the
//                   current pixel when no earlier overlap was captured
// ---------------------------------------------------------------------------
module overlap_frame_counter
    import obstacle_collision_detector_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pixelEn,
    input  logic [9:0] vgaX,
    input  logic [8:0] vgaY,
    input  logic       overlapPix,
    input  logic       frameEnd,
    input  logic       freeze,
    input  logic       clear,
    output logic [7:0] overlapCount,
    output logic [7:0] frameTotal,
    output logic [9:0] firstX,
    output logic [8:0] firstY
);

    logic [7:0] pix_cnt;
    logic       first_valid;
    logic [9:0] first_x;
    logic [8:0] first_y;

    // Saturating sum so an overlap on the frame-end pixel still counts
    assign frameTotal = (overlapPix && (pix_cnt != 8'hFF)) ? pix_cnt + 8'd1 : pix_cnt;

    // Lets the FSM load the hit position even when the first overlap of
    // the frame is the frame-end pixel itself
    assign firstX = first_valid ? first_x : vgaX;
    assign firstY = first_valid ? first_y : vgaY;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt      <= 8'd0;
            first_valid  <= 1'b0;
            first_x      <= 10'd0;
            first_y      <= 9'd0;
            overlapCount <= 8'd0;
        end else if (clear) begin
            pix_cnt      <= 8'd0;
            first_valid  <= 1'b0;
            first_x      <= 10'd0;
            first_y      <= 9'd0;
            overlapCount <= 8'd0;
        end else if (pixelEn && !freeze) begin
            if (frameEnd) begin
                overlapCount <= frameTotal;
                pix_cnt      <= 8'd0;
                first_valid  <= 1'b0;
            end else begin
                pix_cnt <= frameTotal;
                if (overlapPix && !first_valid) begin
                    first_valid <= 1'b1;
                    first_x     <= vgaX;
                    first_y     <= vgaY;
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_collision_detector.sv
// ---------------------------------------------------------------------------
// obstacle_collision_detector
// Compares obstacle and dino sprite pixels over each VGA frame, counts
// overlapping solid pixels and declares a hit at frame end once the grace
// period after run start has elapsed.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   pixelEn            pixel enable aligned with vgaX/vgaY
//   vgaX, vgaY         current pixel position
//   gameState          00 idle, 10 running, 01/11 paused
//   obsInGrey          solid obstacle pixel
//   dinoInGrey         solid dino pixel
//   X_1, Obs1_W        obstacle left edge and width
//   dinoX, dinoW       dino left edge and width
//   collide            one-cycle pulse when a hit is declared
//   gameOver           held from hit until gameState returns to idle
//   overlapCount       overlap count of the last completed frame
//   hitX, hitY         first overlap position of the hit frame
// ---------------------------------------------------------------------------
module obstacle_collision_detector
    import obstacle_collision_detector_pkg::*;
#(
    parameter int PIX_THRESH   = 4,
    parameter int GRACE_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixelEn,
    input  logic [9:0]  vgaX,
    input  logic [8:0]  vgaY,
    input  logic [1:0]  gameState,
    input  logic        obsInGrey,
    input  logic        dinoInGrey,
    input  logic [10:0] X_1,
    input  logic [7:0]  Obs1_W,
    input  logic [9:0]  dinoX,
    input  logic [7:0]  dinoW,
    output logic        collide,
    output logic        gameOver,
    output logic [7:0]  overlapCount,
    output logic [9:0]  hitX,
    output logic [8:0]  hitY
);

    localparam logic [7:0] THRESH     = 8'(PIX_THRESH);
    localparam logic [8:0] GRACE_LAST = 9'(GRACE_FRAMES);

    fsm_state_t  state;
    logic [7:0]  grace_cnt;
    logic [11:0] obs_l, obs_r, dino_l, dino_r;
    logic        box_ok, overlap_pix, frame_end;
    logic        go_idle, running, paused, hit_now;
    logic [7:0]  frame_total;
    logic [9:0]  first_x;
    logic [8:0]  first_y;

    // 12-bit box edges: X_1 may sit beyond the screen and X_1+Obs1_W must
    // not wrap, otherwise an off-screen obstacle could look overlapping
    assign obs_l  = {1'b0, X_1};
    assign obs_r  = {1'b0, X_1} + {4'b0, Obs1_W};
    assign dino_l = {2'b0, dinoX};
    assign dino_r = {2'b0, dinoX} + {4'b0, dinoW};
    assign box_ok = (obs_l < dino_r) && (obs_r > dino_l);

    assign overlap_pix = pixelEn && obsInGrey && dinoInGrey && box_ok;
    assign frame_end   = pixelEn && (vgaX == 10'(SCREEN_W - 1)) && (vgaY == 9'(SCREEN_H - 1));

    assign go_idle = (gameState == GS_IDLE);
    assign running = (gameState == GS_RUN);
    assign paused  = gameState[0];

    assign hit_now = (state == ST_ARMED) && running && frame_end && (frame_total >= THRESH);

    overlap_frame_counter u_counter (
        .clk          (clk),
        .rst          (rst),
        .pixelEn      (pixelEn),
        .vgaX         (vgaX),
        .vgaY         (vgaY),
        .overlapPix   (overlap_pix),
        .frameEnd     (frame_end),
        .freeze       (paused),
        .clear        (go_idle || (state == ST_IDLE)),
        .overlapCount (overlapCount),
        .frameTotal   (frame_total),
        .firstX       (first_x),
        .firstY       (first_y)
    );

    // Idle override is checked before the pixelEn-gated transitions so a
    // return to idle beats a hit on the same frame-end pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            grace_cnt <= 8'd0;
            collide   <= 1'b0;
            gameOver  <= 1'b0;
            hitX      <= 10'd0;
            hitY      <= 9'd0;
        end else begin
            collide <= 1'b0;
            if (go_idle) begin
                state     <= ST_IDLE;
                grace_cnt <= 8'd0;
                gameOver  <= 1'b0;
                hitX      <= 10'd0;
                hitY      <= 9'd0;
            end else if (pixelEn) begin
                case (state)
                    ST_IDLE: begin
                        if (running) begin
                            grace_cnt <= 8'd0;
                            if (GRACE_FRAMES == 0) state <= ST_ARMED;
                            else                   state <= ST_GRACE;
                        end
                    end
                    ST_GRACE: begin
                        if (running && frame_end) begin
                            if ({1'b0, grace_cnt} + 9'd1 >= GRACE_LAST) begin
                                state     <= ST_ARMED;
                                grace_cnt <= 8'd0;
                            end else begin
                                grace_cnt <= grace_cnt + 8'd1;
                            end
                        end
                    end
                    ST_ARMED: begin
                        if (hit_now) begin
                            state    <= ST_HIT;
                            collide  <= 1'b1;
                            gameOver <= 1'b1;
                            hitX     <= first_x;
                            hitY     <= first_y;
                        end
                    end
                    ST_HIT: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/obstacle_collision_detector.md
Name: obstacle_collision_detector

Overview:
- Reads the obstacle side of the display interface: obstacle sprite-pixel flags, obstacle X and obstacle width. Compares them against the dino sprite flags and dino box, pixel by pixel over each VGA frame.
- Counts solid-pixel overlaps per frame and evaluates the count at end of frame.
- Sits between the obstacle/dino drawers and the game-state controller. Raises a one-cycle `collide` pulse and a held `gameOver` level that the controller uses to leave the running state.

Parameters:
- PIX_THRESH, 4: minimum overlapping solid pixels in one frame that declares a hit (range 1..255).
- GRACE_FRAMES, 30: frames ignored after the run starts (range 0..255).
- SCREEN_W, 640: active pixels per line.
- SCREEN_H, 480: active lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pixelEn  in  1  one-cycle-per-pixel enable, aligned with vgaX/vgaY.
- vgaX  in  10  current pixel column.
- vgaY  in  9  current pixel row.
- gameState  in  2  00 idle, 10 running, 01 paused, 11 treated as paused.
- obsInGrey  in  1  current pixel is a solid obstacle pixel.
- dinoInGrey  in  1  current pixel is a solid dino pixel.
- X_1  in  11  obstacle left edge (may exceed SCREEN_W).
- Obs1_W  in  8  obstacle width.
- dinoX  in  10  dino left edge.
- dinoW  in  8  dino width.
- collide  out  1  one-cycle pulse on hit declaration.
- gameOver  out  1  held high from hit until gameState==00.
- overlapCount  out  8  overlap count of the last completed frame.
- hitX  out  10  column of the first overlap in the hit frame.
- hitY  out  9  row of the first overlap in the hit frame.

Behaviour:
- Reset (rst low, asynchronous): every output is 0, internal counters are 0, FSM is IDLE.
- All state updates happen only on clk edges with pixelEn=1, except the gameState==00 override, which applies every clk.
- Box gate: boxOverlap = (X_1 < dinoX + dinoW) && (X_1 + Obs1_W > dinoX). Evaluate at 12-bit width with zero extension; no truncation.
- Overlap pixel: pixelEn && obsInGrey && dinoInGrey && boxOverlap.
- Frame end: pixelEn && vgaX==SCREEN_W-1 && vgaY==SCREEN_H-1.
- Frame counter:
  - Increments on each overlap pixel and saturates at 255.
  - Captures vgaX/vgaY into a first-hit register on the first overlap of the frame.
  - An overlap on the frame-end pixel counts toward that frame.
  - At frame end, the count (including that pixel) copies to overlapCount, then the counter and first-hit valid flag clear.
- FSM states:
  - IDLE: counters cleared, gameOver=0. Goes to GRACE when gameState==10. If GRACE_FRAMES==0, goes straight to ARMED.
  - GRACE: counts frame ends. Goes to ARMED after GRACE_FRAMES frame ends. Overlaps are counted and overlapCount updates, but no hit is declared.
  - ARMED: at frame end, if the final count >= PIX_THRESH, go to HIT. On that transition collide=1 for exactly one clk, gameOver=1, and hitX/hitY load from the first-hit register.
  - HIT: gameOver stays 1. No further collide pulses. hitX/hitY are frozen.
- Pause: gameState 01/11 in GRACE or ARMED freezes the grace counter and per-frame counter. Frame ends during pause neither evaluate nor update overlapCount. Resuming continues the same frame count.
- gameState==00 from any state: synchronous return to IDLE on the next clk. Clears gameOver, collide, the counter and the grace count. overlapCount, hitX and hitY also clear.
- Simultaneous gameState==00 and frame-end hit: the idle override wins and no collide is issued.
- A reset asserted mid-frame or mid-grace aborts everything; no partial evaluation happens after release.
- Latency: collide is registered, high the clk after the frame-end pixel.

Decomposition:
- Shared game package holds:
  - gameState encodings (GS_IDLE=00, GS_RUN=10, GS_PAUSE=01)
  - SCREEN_W/SCREEN_H constants
  - FSM state typedef (IDLE, GRACE, ARMED, HIT)
- One natural sub-module: overlap_frame_counter. It contains the saturating per-frame counter, first-hit capture and frame-end snapshot, with freeze and clear inputs. The FSM stays in the top.

Test Plan:
- Reset then gameState=10, GRACE_FRAMES=2, PIX_THRESH=4, 5-pixel overlap in frames 1–2 -> no collide, overlapCount=5 each frame; same overlap in frame 3 -> collide pulse 1 clk after frame end, gameOver=1, hitX/hitY = first overlap pixel.
- ARMED, 3-pixel overlap per frame -> overlapCount=3, no collide; 4 pixels -> collide.
- Flags overlap but X_1=700, Obs1_W=20, dinoX=50, dinoW=40 (boxes disjoint) -> overlapCount=0, no hit.
- ARMED, 300 overlapping pixels -> overlapCount=255 (saturated), collide once; further frames in HIT -> no second pulse.
- Pause (01) for 3 frames mid-grace with GRACE_FRAMES=2 -> grace counter frozen, ARMED reached only after 2 running frame ends; gameState=00 on hit frame-end cycle -> no collide, all outputs 0.
- Assert rst low mid-frame during HIT -> all outputs 0 immediately; release with gameState=10 -> GRACE restarts from 0.
